// File: rtl/atomic_counter_bank_pkg.sv
// Shared types and helpers for the atomic counter bank: read FSM states,
// the registered response record and the word-count helper.
package atomic_counter_pkg;

    // Widest read port the response record can carry.
    localparam int MAX_BUS_W = 64;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_SNAP = 1'b1
    } rd_state_e;

    typedef struct packed {
        logic                 ack;
        logic                 err;
        logic [MAX_BUS_W-1:0] data;
    } rsp_t;

    function automatic int num_words(int cnt_w, int bus_w);
        return cnt_w / bus_w;
    endfunction

endpackage

// File: rtl/atomic_counter_bank_if.sv
// Narrow read port of the counter bank: request/qualifier/channel from the
// host, registered ack/data/error back from the bank.
interface atomic_counter_bank_if #(
    parameter int CH_W  = 2,
    parameter int BUS_W = 32
);
    logic             req_i;
    logic             atomic_i;
    logic [CH_W-1:0]  ch_sel_i;
    logic             ack_o;
    logic [BUS_W-1:0] count_o;
    logic             err_o;

    modport master (
        output req_i, atomic_i, ch_sel_i,
        input  ack_o, count_o, err_o
    );

    modport slave (
        input  req_i, atomic_i, ch_sel_i,
        output ack_o, count_o, err_o
    );
endinterface

// File: rtl/atomic_counter_bank_ch.sv
// Single event counter channel: clear has priority over increment; at
// all-ones an increment either wraps or holds, and always sets the sticky ovf.
module atomic_counter_ch #(
    parameter int CNT_W    = 64,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             trig,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             ovf
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (clr) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (trig) begin
            if (&count) begin
                if (!SATURATE) begin
                    count <= '0;
                end
                ovf <= 1'b1;
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/atomic_counter_bank.sv
// Multi-channel counter bank with an atomic snapshot read: an atomic request
// freezes one channel's full count, later plain requests stream its words out.
//
//   state   | meaning
//   RD_IDLE | no snapshot pending; plain requests answer with err
//   RD_SNAP | snapshot held, rd_ptr selects the next word to return
module atomic_counter_bank
    import atomic_counter_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 64,
    parameter int BUS_W    = 32,
    parameter bit SATURATE = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_CH-1:0]     trig_i,
    input  logic [NUM_CH-1:0]     clr_i,
    atomic_counter_bank_if.slave  bus,
    output logic [NUM_CH-1:0]     ovf_o
);

    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int NUM_WORDS = num_words(CNT_W, BUS_W);
    localparam int PTR_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    if ((CNT_W % BUS_W) != 0 || NUM_CH < 1 || BUS_W > MAX_BUS_W) begin : g_param_err
        $error("atomic_counter_bank: bad NUM_CH/CNT_W/BUS_W combination");
    end

    logic [CNT_W-1:0] cnt [NUM_CH];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        atomic_counter_ch #(
            .CNT_W    (CNT_W),
            .SATURATE (SATURATE)
        ) u_ch (
            .clk   (clk),
            .reset (reset),
            .trig  (trig_i[g]),
            .clr   (clr_i[g]),
            .count (cnt[g]),
            .ovf   (ovf_o[g])
        );
    end

    rd_state_e                         state_q, state_d;
    logic [PTR_W-1:0]                  rd_ptr_q, rd_ptr_d;
    logic [NUM_WORDS-1:0][BUS_W-1:0]   snap_q, snap_d;
    rsp_t                              resp_q, resp_d;

    logic             sel_ok;
    logic [CNT_W-1:0] cnt_sel;
    logic             last_word;

    assign sel_ok    = ({1'b0, bus.ch_sel_i} < (CH_W+1)'(NUM_CH));
    assign last_word = (rd_ptr_q == PTR_W'(NUM_WORDS - 1));

    // Loop-based select keeps out-of-range channel codes from indexing cnt[].
    always_comb begin
        cnt_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.ch_sel_i == CH_W'(i)) begin
                cnt_sel = cnt[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= RD_IDLE;
            rd_ptr_q <= '0;
            snap_q   <= '0;
            resp_q   <= '0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            snap_q   <= snap_d;
            resp_q   <= resp_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rd_ptr_d = rd_ptr_q;
        snap_d   = snap_q;
        if (bus.req_i) begin
            if (bus.atomic_i) begin
                if (sel_ok) begin
                    snap_d = cnt_sel;
                    if (NUM_WORDS > 1) begin
                        state_d  = RD_SNAP;
                        rd_ptr_d = PTR_W'(1);
                    end else begin
                        state_d  = RD_IDLE;
                        rd_ptr_d = '0;
                    end
                end
            end else if (state_q == RD_SNAP) begin
                if (last_word) begin
                    state_d  = RD_IDLE;
                    rd_ptr_d = '0;
                end else begin
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                end
            end
        end
    end

    always_comb begin
        resp_d = '0;
        if (bus.req_i) begin
            resp_d.ack = 1'b1;
            if (bus.atomic_i) begin
                if (sel_ok) begin
                    resp_d.data[BUS_W-1:0] = cnt_sel[BUS_W-1:0];
                end else begin
                    resp_d.err = 1'b1;
                end
            end else if (state_q == RD_SNAP) begin
                resp_d.data[BUS_W-1:0] = snap_q[rd_ptr_q];
            end else begin
                resp_d.err = 1'b1;
            end
        end
    end

    assign bus.ack_o   = resp_q.ack;
    assign bus.err_o   = resp_q.err;
    assign bus.count_o = resp_q.data[BUS_W-1:0];

    // Upper response bits beyond the port width are constant zero.
    if (BUS_W < MAX_BUS_W) begin : g_rsp_pad
        logic [MAX_BUS_W-BUS_W-1:0] rsp_pad_unused;
        assign rsp_pad_unused = resp_q.data[MAX_BUS_W-1:BUS_W];
    end

endmodule

// File: tb/tb_atomic_counter_bank.sv
// Scoreboard bench for atomic_counter_bank across five parameter sets:
// requests push expected responses, a negedge monitor pops on every ack.
module tb_atomic_counter_bank;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [3:0] trig [5];
    logic [3:0] clr  [5];
    logic [4:0] req_v, atomic_v;
    logic [1:0] sel_v [5];
    logic [4:0] ack_v, err_v;
    logic [63:0] dat_v [5];
    logic [3:0] ovf_a, ovf_b, ovf_c, ovf_d;
    logic [2:0] ovf_e;

    atomic_counter_bank_if #(.CH_W(2), .BUS_W(32)) if_a ();
    atomic_counter_bank_if #(.CH_W(2), .BUS_W(8))  if_b ();
    atomic_counter_bank_if #(.CH_W(2), .BUS_W(4))  if_c ();
    atomic_counter_bank_if #(.CH_W(2), .BUS_W(4))  if_d ();
    atomic_counter_bank_if #(.CH_W(2), .BUS_W(32)) if_e ();

    assign if_a.req_i = req_v[0]; assign if_a.atomic_i = atomic_v[0]; assign if_a.ch_sel_i = sel_v[0];
    assign if_b.req_i = req_v[1]; assign if_b.atomic_i = atomic_v[1]; assign if_b.ch_sel_i = sel_v[1];
    assign if_c.req_i = req_v[2]; assign if_c.atomic_i = atomic_v[2]; assign if_c.ch_sel_i = sel_v[2];
    assign if_d.req_i = req_v[3]; assign if_d.atomic_i = atomic_v[3]; assign if_d.ch_sel_i = sel_v[3];
    assign if_e.req_i = req_v[4]; assign if_e.atomic_i = atomic_v[4]; assign if_e.ch_sel_i = sel_v[4];

    assign ack_v = {if_e.ack_o, if_d.ack_o, if_c.ack_o, if_b.ack_o, if_a.ack_o};
    assign err_v = {if_e.err_o, if_d.err_o, if_c.err_o, if_b.err_o, if_a.err_o};
    assign dat_v[0] = 64'(if_a.count_o);
    assign dat_v[1] = 64'(if_b.count_o);
    assign dat_v[2] = 64'(if_c.count_o);
    assign dat_v[3] = 64'(if_d.count_o);
    assign dat_v[4] = 64'(if_e.count_o);

    atomic_counter_bank #(.NUM_CH(4), .CNT_W(64), .BUS_W(32), .SATURATE(1'b0)) dut_a (
        .clk(clk), .reset(reset), .trig_i(trig[0]), .clr_i(clr[0]), .bus(if_a), .ovf_o(ovf_a));
    atomic_counter_bank #(.NUM_CH(4), .CNT_W(16), .BUS_W(8), .SATURATE(1'b0)) dut_b (
        .clk(clk), .reset(reset), .trig_i(trig[1]), .clr_i(clr[1]), .bus(if_b), .ovf_o(ovf_b));
    atomic_counter_bank #(.NUM_CH(4), .CNT_W(8), .BUS_W(4), .SATURATE(1'b0)) dut_c (
        .clk(clk), .reset(reset), .trig_i(trig[2]), .clr_i(clr[2]), .bus(if_c), .ovf_o(ovf_c));
    atomic_counter_bank #(.NUM_CH(4), .CNT_W(8), .BUS_W(4), .SATURATE(1'b1)) dut_d (
        .clk(clk), .reset(reset), .trig_i(trig[3]), .clr_i(clr[3]), .bus(if_d), .ovf_o(ovf_d));
    atomic_counter_bank #(.NUM_CH(3), .CNT_W(64), .BUS_W(32), .SATURATE(1'b0)) dut_e (
        .clk(clk), .reset(reset), .trig_i(trig[4][2:0]), .clr_i(clr[4][2:0]), .bus(if_e), .ovf_o(ovf_e));

    typedef struct {
        int          id;
        int          cyc;
        logic        err;
        logic [63:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < 5; i++) begin
                if (ack_v[i] === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_ack dut%0d actual=ack required=no_ack", i);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk($sformatf("ack_dut%0d", i), 64'(i), 64'(e.id));
                        chk($sformatf("ack_cycle%0d", i), 64'(cyc), 64'(e.cyc));
                        chk($sformatf("err%0d", i), 64'(err_v[i]), 64'(e.err));
                        chk($sformatf("data%0d", i), dat_v[i], e.data);
                    end
                end else begin
                    chk($sformatf("idle_out%0d", i), dat_v[i] | {62'b0, ack_v[i], err_v[i]}, 64'h0);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int id, input bit at, input int sel, input bit e, input logic [63:0] d);
        exp_t x;
        req_v[id]    = 1'b1;
        atomic_v[id] = at;
        sel_v[id]    = 2'(sel);
        x.id   = id;
        x.cyc  = cyc + 1;
        x.err  = e;
        x.data = d;
        exp_q.push_back(x);
        step();
        req_v[id]    = 1'b0;
        atomic_v[id] = 1'b0;
    endtask

    initial begin
        // Reset held with every input active: nothing may respond.
        reset    = 1'b0;
        req_v    = '1;
        atomic_v = '1;
        for (int i = 0; i < 5; i++) begin
            trig[i]  = '1;
            clr[i]   = '0;
            sel_v[i] = '0;
        end
        step();
        mon_en = 1'b1;
        repeat (2) begin
            chk("rst_ovf", 64'({ovf_a, ovf_b, ovf_c, ovf_d, ovf_e}), 64'h0);
            step();
        end
        chk("rst_ovf", 64'({ovf_a, ovf_b, ovf_c, ovf_d, ovf_e}), 64'h0);

        reset    = 1'b1;
        req_v    = '0;
        atomic_v = '0;
        for (int i = 0; i < 5; i++) trig[i] = '0;
        step();
        issue(0, 1, 0, 0, 64'h0);
        issue(0, 0, 0, 0, 64'h0);

        // Five events on ch2, read it, drain, then one extra plain read.
        trig[0][2] = 1'b1;
        repeat (5) step();
        trig[0][2] = 1'b0;
        issue(0, 1, 2, 0, 64'd5);
        issue(0, 0, 0, 0, 64'h0);
        issue(0, 0, 0, 1, 64'h0);

        // Snapshot coherence across a carry into the high byte.
        trig[1][0] = 1'b1;
        repeat (255) step();
        trig[1][0] = 1'b0;
        issue(1, 1, 0, 0, 64'hFF);
        trig[1][0] = 1'b1;
        step();
        trig[1][0] = 1'b0;
        issue(1, 0, 0, 0, 64'h00);
        issue(1, 1, 0, 0, 64'h00);
        issue(1, 0, 0, 0, 64'h01);
        chk("ovf_b", 64'(ovf_b), 64'h0);

        // 300 events on ch1 (wrap vs saturate); ch3 overflows, ch0 gets 7.
        for (int k = 0; k < 300; k++) begin
            trig[2][1] = 1'b1;
            trig[3][1] = 1'b1;
            trig[2][3] = (k < 260);
            trig[2][0] = (k < 7);
            step();
        end
        trig[2] = '0;
        trig[3] = '0;
        chk("ovf_c", 64'(ovf_c), 64'hA);
        chk("ovf_d", 64'(ovf_d), 64'h2);
        issue(2, 1, 1, 0, 64'hC);
        issue(2, 0, 0, 0, 64'h2);
        issue(3, 1, 1, 0, 64'hF);
        issue(3, 0, 0, 0, 64'hF);

        // Clear beats a same-cycle trigger and drops ch3's overflow only.
        clr[2][3]  = 1'b1;
        trig[2][3] = 1'b1;
        step();
        clr[2][3]  = 1'b0;
        trig[2][3] = 1'b0;
        chk("ovf_c_clr", 64'(ovf_c), 64'h2);
        issue(2, 1, 3, 0, 64'h0);
        issue(2, 0, 0, 0, 64'h0);
        issue(2, 1, 0, 0, 64'h7);
        issue(2, 0, 0, 0, 64'h0);
        issue(2, 1, 1, 0, 64'hC);
        issue(2, 0, 0, 0, 64'h2);

        // Back-to-back on a 3-channel bank, including an invalid channel.
        trig[4][2] = 1'b1;
        repeat (3) step();
        trig[4][2] = 1'b0;
        issue(4, 1, 2, 0, 64'd3);
        issue(4, 0, 0, 0, 64'h0);
        issue(4, 1, 3, 1, 64'h0);
        issue(4, 0, 0, 1, 64'h0);

        // Reset in the middle of a two-word read discards the snapshot.
        trig[0][1] = 1'b1;
        repeat (2) step();
        trig[0][1] = 1'b0;
        issue(0, 1, 1, 0, 64'd2);
        reset = 1'b0;
        step();
        reset = 1'b1;
        issue(0, 0, 0, 1, 64'h0);
        issue(0, 1, 2, 0, 64'h0);
        chk("ovf_c_after_rst", 64'(ovf_c), 64'h0);

        repeat (3) step();
        chk("queue_drained", 64'(exp_q.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
